// File: rtl/hwpe_ctrl_package.sv
// Shared definitions for the HWPE control job offloader.
// Contents: slave register-file word offsets, ACQUIRE busy response codes,
// the offloader FSM state type and a helper that builds a byte address
// from a base and a word offset.
// Build option: HWPE_CTRL_OFFLOADER_POLL_EN adds the STATUS polling states.
package hwpe_ctrl_package;

  localparam int unsigned REGFILE_OFFS_TRIGGER   = 0;
  localparam int unsigned REGFILE_OFFS_ACQUIRE   = 1;
  localparam int unsigned REGFILE_OFFS_STATUS    = 3;
  localparam int unsigned REGFILE_JOB_REG_OFFSET = 16;

  localparam logic [31:0] RESP_ANOTHER_PE_OFFLOADING = 32'hFFFF_FFFE;
  localparam logic [31:0] RESP_ALL_CXT_BUSY          = 32'hFFFF_FFFF;

  typedef enum logic [3:0] {
    OFFL_IDLE,
    OFFL_ACQ_REQ,
    OFFL_ACQ_RESP,
    OFFL_BACKOFF,
    OFFL_WR_REQ,
    OFFL_WR_RESP,
    OFFL_TRIG_REQ,
    OFFL_TRIG_RESP
`ifdef HWPE_CTRL_OFFLOADER_POLL_EN
    ,
    OFFL_POLL_REQ,
    OFFL_POLL_RESP,
    OFFL_POLL_WAIT
`endif
  } offloader_state_t;

  function automatic logic [31:0] regfile_addr(input logic [31:0] base,
                                               input int unsigned offs);
    return base + (offs << 2);
  endfunction

endpackage

// File: rtl/hwpe_ctrl_periph_master_port.sv
// Single-outstanding peripheral bus initiator.
// A one-cycle start_i captures address/wen/data into output registers and
// raises periph_req_o; the payload stays frozen until the grant cycle, req
// drops the cycle after the grant, and the first r_valid after the grant
// completes the transaction (rsp_valid_o). r_valid at any other time is
// ignored. start_i is only honoured while no transaction is active.
// Ports: clk_i, rst_ni (sync, active-low), clear_i (sync soft clear),
//        start_i/add_i/wen_i/data_i (request), rsp_valid_o/rsp_data_o
//        (response), periph_* (bus initiator side).
module hwpe_ctrl_periph_master_port #(
  parameter int unsigned ID_WIDTH  = 16,
  parameter int unsigned MASTER_ID = 0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                start_i,
  input  logic [31:0]         add_i,
  input  logic                wen_i,
  input  logic [31:0]         data_i,
  output logic                rsp_valid_o,
  output logic [31:0]         rsp_data_o,
  output logic                periph_req_o,
  input  logic                periph_gnt_i,
  output logic [31:0]         periph_add_o,
  output logic                periph_wen_o,
  output logic [3:0]          periph_be_o,
  output logic [31:0]         periph_data_o,
  output logic [ID_WIDTH-1:0] periph_id_o,
  input  logic [31:0]         periph_r_data_i,
  input  logic                periph_r_valid_i
);

  logic        req_q, req_d;
  logic        pend_q, pend_d;
  logic [31:0] add_q, data_q;
  logic        wen_q;
  logic        launch;

  assign launch = start_i && !req_q && !pend_q;

  always_comb begin
    req_d  = req_q;
    pend_d = pend_q;
    if (launch) begin
      req_d = 1'b1;
    end else if (req_q && periph_gnt_i) begin
      req_d  = 1'b0;
      pend_d = 1'b1;
    end else if (pend_q && periph_r_valid_i) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      req_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      req_q  <= req_d;
      pend_q <= pend_d;
    end
  end

  // Payload is captured only at launch, so it is stable for the whole request phase.
  always_ff @(posedge clk_i) begin
    if (launch) begin
      add_q  <= add_i;
      wen_q  <= wen_i;
      data_q <= data_i;
    end
  end

  assign rsp_valid_o   = pend_q & periph_r_valid_i;
  assign rsp_data_o    = periph_r_data_i;
  assign periph_req_o  = req_q;
  assign periph_add_o  = add_q;
  assign periph_wen_o  = wen_q;
  assign periph_data_o = data_q;
  assign periph_be_o   = 4'hF;
  assign periph_id_o   = ID_WIDTH'(MASTER_ID);

endmodule

// File: rtl/hwpe_ctrl_job_offloader.sv
// Offloads one job at a time to an HWPE control slave.
// Sequence per job: ACQUIRE read (retried with back-off while the slave
// reports busy), N_IO_REGS job-register writes, TRIGGER write and, when
// HWPE_CTRL_OFFLOADER_POLL_EN is defined, STATUS polling until it reads 0.
// Ports: clk_i, rst_ni (sync, active-low), clear_i (sync soft clear);
//        job_valid_i/job_ready_o/job_params_i (job descriptor input);
//        job_id_o/job_id_valid_o, done_o, error_o, busy_o (status);
//        periph_* (bus initiator towards the slave register file).
module hwpe_ctrl_job_offloader
  import hwpe_ctrl_package::*;
#(
  parameter int unsigned N_IO_REGS      = 2,
  parameter int unsigned ID_WIDTH       = 16,
  parameter int unsigned MASTER_ID      = 0,
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter int unsigned BACKOFF_CYCLES = 8,
  parameter int unsigned MAX_RETRIES    = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   job_valid_i,
  output logic                   job_ready_o,
  input  logic [N_IO_REGS*32-1:0] job_params_i,
  output logic [7:0]             job_id_o,
  output logic                   job_id_valid_o,
  output logic                   done_o,
  output logic                   error_o,
  output logic                   busy_o,
  output logic                   periph_req_o,
  input  logic                   periph_gnt_i,
  output logic [31:0]            periph_add_o,
  output logic                   periph_wen_o,
  output logic [3:0]             periph_be_o,
  output logic [31:0]            periph_data_o,
  output logic [ID_WIDTH-1:0]    periph_id_o,
  input  logic [31:0]            periph_r_data_i,
  input  logic                   periph_r_valid_i
);

  localparam int unsigned KW           = (N_IO_REGS > 1) ? $clog2(N_IO_REGS) : 1;
  localparam logic [KW-1:0] K_LAST     = KW'(N_IO_REGS - 1);
  localparam logic [15:0] WAIT_INIT    = 16'(BACKOFF_CYCLES - 1);
  localparam logic [15:0] RETRY_LIMIT  = 16'(MAX_RETRIES);

  offloader_state_t        state_q;
  logic [N_IO_REGS*32-1:0] params_q;
  logic [KW-1:0]           k_q;
  logic [15:0]             retry_q;
  logic [15:0]             wait_q;
  logic [7:0]              job_id_q;
  logic                    id_valid_q, done_q, error_q;

  logic        start;
  logic [31:0] req_add, req_data;
  logic        req_wen;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        ready;

  // Ready is withheld during the done/error pulse so consecutive jobs see at least one idle cycle.
  assign ready = (state_q == OFFL_IDLE) && !done_q && !error_q;

  always_comb begin
    start    = 1'b0;
    req_add  = regfile_addr(BASE_ADDR, REGFILE_OFFS_ACQUIRE);
    req_wen  = 1'b1;
    req_data = '0;
    case (state_q)
      OFFL_ACQ_REQ: start = 1'b1;
      OFFL_WR_REQ: begin
        start    = 1'b1;
        req_add  = regfile_addr(BASE_ADDR, REGFILE_JOB_REG_OFFSET + 32'(k_q));
        req_wen  = 1'b0;
        req_data = params_q[32*k_q +: 32];
      end
      OFFL_TRIG_REQ: begin
        start   = 1'b1;
        req_add = regfile_addr(BASE_ADDR, REGFILE_OFFS_TRIGGER);
        req_wen = 1'b0;
      end
`ifdef HWPE_CTRL_OFFLOADER_POLL_EN
      OFFL_POLL_REQ: begin
        start   = 1'b1;
        req_add = regfile_addr(BASE_ADDR, REGFILE_OFFS_STATUS);
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      state_q    <= OFFL_IDLE;
      k_q        <= '0;
      retry_q    <= '0;
      wait_q     <= '0;
      job_id_q   <= '0;
      id_valid_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      id_valid_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      case (state_q)
        OFFL_IDLE: begin
          if (job_valid_i && ready) begin
            params_q <= job_params_i;
            retry_q  <= '0;
            state_q  <= OFFL_ACQ_REQ;
          end
        end
        OFFL_ACQ_REQ: state_q <= OFFL_ACQ_RESP;
        OFFL_ACQ_RESP: begin
          if (rsp_valid) begin
            if (rsp_data == RESP_ANOTHER_PE_OFFLOADING || rsp_data == RESP_ALL_CXT_BUSY) begin
              retry_q <= retry_q + 16'd1;
              if (MAX_RETRIES != 0 && (retry_q + 16'd1) == RETRY_LIMIT) begin
                error_q <= 1'b1;
                state_q <= OFFL_IDLE;
              end else begin
                wait_q  <= WAIT_INIT;
                state_q <= OFFL_BACKOFF;
              end
            end else begin
              job_id_q   <= rsp_data[7:0];
              id_valid_q <= 1'b1;
              k_q        <= '0;
              state_q    <= OFFL_WR_REQ;
            end
          end
        end
        OFFL_BACKOFF: begin
          if (wait_q == '0) state_q <= OFFL_ACQ_REQ;
          else              wait_q  <= wait_q - 16'd1;
        end
        OFFL_WR_REQ: state_q <= OFFL_WR_RESP;
        OFFL_WR_RESP: begin
          if (rsp_valid) begin
            if (k_q == K_LAST) begin
              state_q <= OFFL_TRIG_REQ;
            end else begin
              k_q     <= k_q + KW'(1);
              state_q <= OFFL_WR_REQ;
            end
          end
        end
        OFFL_TRIG_REQ: state_q <= OFFL_TRIG_RESP;
        OFFL_TRIG_RESP: begin
          if (rsp_valid) begin
`ifdef HWPE_CTRL_OFFLOADER_POLL_EN
            state_q <= OFFL_POLL_REQ;
`else
            done_q  <= 1'b1;
            state_q <= OFFL_IDLE;
`endif
          end
        end
`ifdef HWPE_CTRL_OFFLOADER_POLL_EN
        OFFL_POLL_REQ: state_q <= OFFL_POLL_RESP;
        OFFL_POLL_RESP: begin
          if (rsp_valid) begin
            if (rsp_data == 32'h0) begin
              done_q  <= 1'b1;
              state_q <= OFFL_IDLE;
            end else begin
              wait_q  <= WAIT_INIT;
              state_q <= OFFL_POLL_WAIT;
            end
          end
        end
        OFFL_POLL_WAIT: begin
          if (wait_q == '0) state_q <= OFFL_POLL_REQ;
          else              wait_q  <= wait_q - 16'd1;
        end
`endif
        default: state_q <= OFFL_IDLE;
      endcase
    end
  end

  hwpe_ctrl_periph_master_port #(
    .ID_WIDTH  (ID_WIDTH),
    .MASTER_ID (MASTER_ID)
  ) i_port (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .clear_i          (clear_i),
    .start_i          (start),
    .add_i            (req_add),
    .wen_i            (req_wen),
    .data_i           (req_data),
    .rsp_valid_o      (rsp_valid),
    .rsp_data_o       (rsp_data),
    .periph_req_o     (periph_req_o),
    .periph_gnt_i     (periph_gnt_i),
    .periph_add_o     (periph_add_o),
    .periph_wen_o     (periph_wen_o),
    .periph_be_o      (periph_be_o),
    .periph_data_o    (periph_data_o),
    .periph_id_o      (periph_id_o),
    .periph_r_data_i  (periph_r_data_i),
    .periph_r_valid_i (periph_r_valid_i)
  );

  assign job_ready_o    = ready;
  assign busy_o         = ~ready;
  assign job_id_o       = job_id_q;
  assign job_id_valid_o = id_valid_q;
  assign done_o         = done_q;
  assign error_o        = error_q;

endmodule

// File: tb/tb_hwpe_ctrl_job_offloader.sv
// Scoreboard bench for hwpe_ctrl_job_offloader: a behavioural slave grants
// requests, compares each granted transaction with the expected queue and
// answers reads from a response queue. Covers HWPE_CTRL_OFFLOADER_POLL_EN
// when that macro is defined for the build.
module tb_hwpe_ctrl_job_offloader;

  localparam int          N_IO    = 2;
  localparam int          IDW     = 16;
  localparam int          MID     = 7;
  localparam logic [31:0] BASE    = 32'h0;
  localparam int          BACKOFF = 8;
  localparam int          MAXR    = 3;

  localparam logic [31:0] ACQ_A  = BASE + 32'h4;
  localparam logic [31:0] STAT_A = BASE + 32'hC;
  localparam logic [31:0] TRIG_A = BASE + 32'h0;
  localparam logic [31:0] JOB0_A = BASE + 32'h40;

  logic              clk = 1'b0;
  logic              rst_ni, clear_i, job_valid_i;
  logic              job_ready_o, job_id_valid_o, done_o, error_o, busy_o;
  logic [N_IO*32-1:0] job_params_i;
  logic [7:0]        job_id_o;
  logic              periph_req_o, periph_gnt_i, periph_wen_o, periph_r_valid_i;
  logic [31:0]       periph_add_o, periph_data_o, periph_r_data_i;
  logic [3:0]        periph_be_o;
  logic [IDW-1:0]    periph_id_o;

  hwpe_ctrl_job_offloader #(
    .N_IO_REGS(N_IO), .ID_WIDTH(IDW), .MASTER_ID(MID), .BASE_ADDR(BASE),
    .BACKOFF_CYCLES(BACKOFF), .MAX_RETRIES(MAXR)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i),
    .job_valid_i(job_valid_i), .job_ready_o(job_ready_o), .job_params_i(job_params_i),
    .job_id_o(job_id_o), .job_id_valid_o(job_id_valid_o), .done_o(done_o),
    .error_o(error_o), .busy_o(busy_o),
    .periph_req_o(periph_req_o), .periph_gnt_i(periph_gnt_i), .periph_add_o(periph_add_o),
    .periph_wen_o(periph_wen_o), .periph_be_o(periph_be_o), .periph_data_o(periph_data_o),
    .periph_id_o(periph_id_o), .periph_r_data_i(periph_r_data_i),
    .periph_r_valid_i(periph_r_valid_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] add;
    logic        wen;
    logic [31:0] data;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] rsp_q[$];
  logic [7:0]  id_q[$];

  int n_checks = 0, n_fail = 0;
  int cyc = 0, done_cnt = 0, err_cnt = 0;
  int rsp_delay = 0, stall_left = 0, stall_checks = 0, last_acq_cyc = 0;
  bit stall_arm = 0, just_gnt = 0, pend = 0, acq_busy_last = 0, wr_granted = 0;
  int pend_dly = 0;
  logic [31:0] pend_data, h_add, h_data;
  logic        h_wen;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic txn_t mk(input logic [31:0] a, input logic w, input logic [31:0] d);
    mk.add = a; mk.wen = w; mk.data = d;
  endfunction

  task automatic push_acq(input logic [31:0] r);
    exp_q.push_back(mk(ACQ_A, 1'b1, 32'h0));
    rsp_q.push_back(r);
  endtask

  task automatic push_writes(input logic [31:0] a, input logic [31:0] b);
    exp_q.push_back(mk(JOB0_A, 1'b0, a));
    exp_q.push_back(mk(JOB0_A + 32'h4, 1'b0, b));
  endtask

  task automatic push_status(input logic [31:0] r);
    exp_q.push_back(mk(STAT_A, 1'b1, 32'h0));
    rsp_q.push_back(r);
  endtask

  // Trigger write, followed by one STATUS read answering "idle" in the polling build.
  task automatic push_tail();
    exp_q.push_back(mk(TRIG_A, 1'b0, 32'h0));
`ifdef HWPE_CTRL_OFFLOADER_POLL_EN
    push_status(32'h0);
`endif
  endtask

  task automatic send_job(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 50; i++) begin
      if (job_ready_o) break;
      @(posedge clk); #2;
    end
    check_val("ready_before_job", job_ready_o, 1'b1);
    job_params_i = {b, a};
    job_valid_i  = 1'b1;
    @(posedge clk); #2;
    job_valid_i  = 1'b0;
    check_val("busy_after_accept", busy_o, 1'b1);
  endtask

  task automatic wait_done(input int n);
    for (int i = 0; i < 600; i++) begin
      if (done_cnt >= n) break;
      @(posedge clk); #2;
    end
    check_val("done_count", done_cnt, n);
    check_val("ready_after_done", job_ready_o, 1'b1);
  endtask

  // Behavioural slave and output monitor, evaluated on the falling edge.
  initial begin
    txn_t t;
    periph_gnt_i = 1'b0; periph_r_valid_i = 1'b0; periph_r_data_i = 32'h0;
    forever begin
      @(negedge clk);
      cyc++;
      periph_gnt_i = 1'b0;
      periph_r_valid_i = 1'b0;
      if (just_gnt) begin
        check_val("req_drop_after_gnt", periph_req_o, 1'b0);
        just_gnt = 0;
      end
      if (job_id_valid_o) begin
        if (id_q.size() == 0) check_val("job_id_valid_expected", id_q.size(), 1);
        else check_val("job_id", job_id_o, id_q.pop_front());
      end
      if (done_o) begin
        done_cnt++;
        check_val("ready_low_during_done", job_ready_o, 1'b0);
        check_val("txns_left_at_done", exp_q.size(), 0);
      end
      if (error_o) begin
        err_cnt++;
        check_val("txns_left_at_error", exp_q.size(), 0);
      end
      if (pend) begin
        if (pend_dly == 0) begin
          periph_r_valid_i = 1'b1;
          periph_r_data_i  = pend_data;
          pend = 0;
        end else pend_dly--;
      end else if (periph_req_o) begin
        if (stall_arm && !periph_wen_o) begin
          stall_arm = 0; stall_left = 10; stall_checks = 0;
          h_add = periph_add_o; h_data = periph_data_o; h_wen = periph_wen_o;
        end
        if (stall_left > 0) begin
          check_val("stall_add_stable", periph_add_o, h_add);
          check_val("stall_data_stable", periph_data_o, h_data);
          check_val("stall_wen_stable", periph_wen_o, h_wen);
          stall_checks++;
          stall_left--;
        end else begin
          periph_gnt_i = 1'b1;
          just_gnt = 1;
          if (periph_add_o == ACQ_A && periph_wen_o) begin
            if (acq_busy_last)
              check_val("backoff_gap", (cyc - last_acq_cyc) > BACKOFF, 1'b1);
            last_acq_cyc = cyc;
          end
          if (!periph_wen_o && periph_add_o >= JOB0_A) wr_granted = 1;
          if (exp_q.size() == 0) begin
            check_val("txn_expected", exp_q.size(), 1);
          end else begin
            t = exp_q.pop_front();
            check_val("txn_add", periph_add_o, t.add);
            check_val("txn_wen", periph_wen_o, t.wen);
            check_val("txn_be", periph_be_o, 4'hF);
            check_val("txn_id", periph_id_o, MID);
            if (!t.wen) check_val("txn_data", periph_data_o, t.data);
          end
          pend = 1;
          pend_dly = rsp_delay;
          pend_data = 32'h0;
          if (periph_wen_o && rsp_q.size() > 0) pend_data = rsp_q.pop_front();
          if (periph_add_o == ACQ_A && periph_wen_o)
            acq_busy_last = (pend_data == 32'hFFFF_FFFF) || (pend_data == 32'hFFFF_FFFE);
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL global_timeout: simulation did not finish, observed %0d done expected completion", done_cnt);
    $fatal(1, "timeout");
  end

  initial begin
    int exp_done;
    exp_done = 0;
    rst_ni = 1'b0; clear_i = 1'b0; job_valid_i = 1'b0; job_params_i = '0;
    repeat (3) @(posedge clk);
    #2 rst_ni = 1'b1;
    check_val("rst_req", periph_req_o, 1'b0);
    check_val("rst_ready", job_ready_o, 1'b1);
    check_val("rst_busy", busy_o, 1'b0);
    check_val("rst_job_id", job_id_o, 8'h0);
    check_val("rst_done", done_o, 1'b0);
    check_val("rst_error", error_o, 1'b0);
    check_val("rst_id_valid", job_id_valid_o, 1'b0);

    // Basic job: id 5, two register writes, trigger.
    id_q.push_back(8'd5);
    push_acq(32'd5); push_writes(32'hAAAA_0001, 32'hBBBB_0002); push_tail();
    send_job(32'hAAAA_0001, 32'hBBBB_0002);
    exp_done++; wait_done(exp_done);
    check_val("t1_job_id_held", job_id_o, 8'd5);

    // Two busy ACQUIRE answers, then id 3.
    id_q.push_back(8'd3);
    push_acq(32'hFFFF_FFFF); push_acq(32'hFFFF_FFFF); push_acq(32'd3);
    push_writes(32'h1234_5678, 32'h9ABC_DEF0); push_tail();
    send_job(32'h1234_5678, 32'h9ABC_DEF0);
    exp_done++; wait_done(exp_done);
    check_val("t2_no_error", err_cnt, 0);
    check_val("t2_job_id", job_id_o, 8'd3);

    // Retry limit: every ACQUIRE answers "another PE offloading".
    for (int i = 0; i < MAXR; i++) push_acq(32'hFFFF_FFFE);
    send_job(32'hDEAD_0000, 32'hDEAD_0001);
    for (int i = 0; i < 400; i++) begin
      if (err_cnt > 0) break;
      @(posedge clk); #2;
    end
    check_val("t3_error_count", err_cnt, 1);
    repeat (4) @(posedge clk); #2;
    check_val("t3_idle_ready", job_ready_o, 1'b1);
    check_val("t3_no_done", done_cnt, exp_done);
    check_val("t3_no_writes", exp_q.size(), 0);
    check_val("t3_job_id_held", job_id_o, 8'd3);

    // Grant withheld for 10 cycles on the first register write.
    stall_arm = 1;
    id_q.push_back(8'd9);
    push_acq(32'd9); push_writes(32'hC0C0_C0C0, 32'hD0D0_D0D0); push_tail();
    send_job(32'hC0C0_C0C0, 32'hD0D0_D0D0);
    exp_done++; wait_done(exp_done);
    check_val("t4_stall_cycles", stall_checks, 10);

`ifdef HWPE_CTRL_OFFLOADER_POLL_EN
    // STATUS answers busy twice before idle.
    id_q.push_back(8'd6);
    push_acq(32'd6); push_writes(32'h0000_0011, 32'h0000_0022);
    exp_q.push_back(mk(TRIG_A, 1'b0, 32'h0));
    push_status(32'd1); push_status(32'd1); push_status(32'd0);
    send_job(32'h0000_0011, 32'h0000_0022);
    exp_done++; wait_done(exp_done);
`endif

    // Soft clear while waiting for a write response, then a clean job.
    wr_granted = 0; rsp_delay = 6;
    id_q.push_back(8'd4);
    push_acq(32'd4); push_writes(32'h5555_0000, 32'h6666_0000); push_tail();
    send_job(32'h5555_0000, 32'h6666_0000);
    for (int i = 0; i < 100; i++) begin
      if (wr_granted) break;
      @(posedge clk); #2;
    end
    check_val("t6_write_granted", wr_granted, 1'b1);
    clear_i = 1'b1;
    @(posedge clk); #2;
    clear_i = 1'b0;
    check_val("t6_clear_ready", job_ready_o, 1'b1);
    check_val("t6_clear_req", periph_req_o, 1'b0);
    check_val("t6_clear_job_id", job_id_o, 8'h0);
    check_val("t6_clear_busy", busy_o, 1'b0);
    exp_q.delete(); rsp_q.delete(); id_q.delete();
    pend = 0; rsp_delay = 0;
    id_q.push_back(8'd2);
    push_acq(32'd2); push_writes(32'h7777_0001, 32'h8888_0002); push_tail();
    send_job(32'h7777_0001, 32'h8888_0002);
    exp_done++; wait_done(exp_done);
    check_val("t6_job_id", job_id_o, 8'd2);
    check_val("end_txns_left", exp_q.size(), 0);
    check_val("end_error_count", err_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
